// File: rtl/cursor_move_entry.sv
// Button-driven cursor and place-strobe generator feeding the game FSM.
// Optional build macro SKIP_OCCUPIED_EN: cursor moves step over occupied cells.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | cursor follows button pulses, place accepted with one turn high
// SETUP     | cursor frozen for SETUP_CYCLES cycles before the strobe
// STROBE    | one-cycle move_x or move_o for the captured player
// WAIT_TURN | wait for the turn flags to change, or give up after timeout
module cursor_move_entry #(
  parameter int START_POS      = 4,
  parameter int SETUP_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_place,
  input  logic       turn_x,
  input  logic       turn_o,
  input  logic [8:0] occ_mask,
  output logic [8:0] sel_pos,
  output logic       move_x,
  output logic       move_o,
  output logic       busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SW = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, WAIT_TURN} state_t;
  typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

  state_t        state, state_n;
  dir_t          dir;
  logic [3:0]    cursor, cursor_n;
  logic [3:0]    step1, target;
  logic          any_dir;
  logic          cap_x, cap_o;
  logic [SW-1:0] setup_cnt;
  logic [TW-1:0] tmo_cnt;

  // One wrapped step on the 3x3 grid; index = 8 - (3*row + col).
  function automatic logic [3:0] step(input logic [3:0] idx, input dir_t d);
    logic [3:0] p;
    logic [1:0] row, col;
    p = 4'd8 - idx;
    case (p)
      4'd0:    begin row = 2'd0; col = 2'd0; end
      4'd1:    begin row = 2'd0; col = 2'd1; end
      4'd2:    begin row = 2'd0; col = 2'd2; end
      4'd3:    begin row = 2'd1; col = 2'd0; end
      4'd4:    begin row = 2'd1; col = 2'd1; end
      4'd5:    begin row = 2'd1; col = 2'd2; end
      4'd6:    begin row = 2'd2; col = 2'd0; end
      4'd7:    begin row = 2'd2; col = 2'd1; end
      default: begin row = 2'd2; col = 2'd2; end
    endcase
    case (d)
      DIR_UP:    row = (row == 2'd0) ? 2'd2 : row - 2'd1;
      DIR_DOWN:  row = (row == 2'd2) ? 2'd0 : row + 2'd1;
      DIR_LEFT:  col = (col == 2'd0) ? 2'd2 : col - 2'd1;
      default:   col = (col == 2'd2) ? 2'd0 : col + 2'd1;
    endcase
    return 4'd8 - ({2'b00, row} * 4'd3 + {2'b00, col});
  endfunction

  assign any_dir = btn_up | btn_down | btn_left | btn_right;

  always_comb begin
    dir = DIR_RIGHT;
    if (btn_up)        dir = DIR_UP;
    else if (btn_down) dir = DIR_DOWN;
    else if (btn_left) dir = DIR_LEFT;
  end

  assign step1 = step(cursor, dir);

`ifdef SKIP_OCCUPIED_EN
  logic [3:0] step2;
  assign step2 = step(step1, dir);

  // Only two other cells exist along a wrapped line; if both are taken, stay.
  always_comb begin
    target = cursor;
    if (!occ_mask[step1])      target = step1;
    else if (!occ_mask[step2]) target = step2;
  end
`else
  logic occ_unused;
  assign occ_unused = ^occ_mask;
  assign target     = step1;
`endif

  always_comb begin
    state_n  = state;
    cursor_n = cursor;
    case (state)
      IDLE: begin
        // Place wins over directions even when it is ignored for a bad turn state.
        if (btn_place) begin
          if (turn_x ^ turn_o) state_n = SETUP;
        end else if (any_dir) begin
          cursor_n = target;
        end
      end
      SETUP: begin
        if (setup_cnt == SW'(SETUP_CYCLES - 1)) state_n = STROBE;
      end
      STROBE: state_n = WAIT_TURN;
      WAIT_TURN: begin
        if ((turn_x != cap_x) || (turn_o != cap_o) ||
            (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)))
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cursor    <= 4'(START_POS);
      sel_pos   <= 9'd1 << START_POS;
      cap_x     <= 1'b0;
      cap_o     <= 1'b0;
      setup_cnt <= '0;
      tmo_cnt   <= '0;
    end else begin
      state   <= state_n;
      cursor  <= cursor_n;
      sel_pos <= 9'd1 << cursor_n;
      if (state == IDLE && state_n == SETUP) begin
        cap_x <= turn_x;
        cap_o <= turn_o;
      end
      if (state != SETUP) setup_cnt <= '0;
      else                setup_cnt <= setup_cnt + 1'b1;
      if (state != WAIT_TURN)                  tmo_cnt <= '0;
      else if (tmo_cnt != TW'(TIMEOUT_CYCLES)) tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign busy   = (state != IDLE);
  assign move_x = (state == STROBE) & cap_x;
  assign move_o = (state == STROBE) & cap_o;

endmodule
